// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } rx_state_t;

    localparam int SYS_CLK_HZ           = 50_000_000;
    localparam int BAUD                 = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / BAUD;
    localparam int MAX_DATA_BITS        = 9;

    // Expected parity bit for a frame; callers zero-extend narrower data.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for an asynchronous serial level; resets to the idle
// (high) level so that reset release never looks like a start bit.
module uart_bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional even/odd parity,
// 1 or 2 stop bits, with glitch rejection and parity/framing/break flags.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Rx_Busy,
    output logic [2:0]           o_Rx_SM
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int H     = (CLKS_PER_BIT - 1) / 2;

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx_cfg: CLKS_PER_BIT must be at least 4");
    end

    logic rx_s;

    uart_bit_sync u_sync (
        .clk   (i_Clock),
        .rst_n (i_Rst_n),
        .d     (i_Rx_Serial),
        .q     (rx_s)
    );

    rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]     clk_cnt, cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, idx_nxt;
    logic                 stop_idx, stop_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 perr, perr_nxt;
    logic                 ferr, ferr_nxt;
    logic                 zero_run, zero_nxt;
    logic                 rx_dv, dv_nxt;
    logic [DATA_BITS-1:0] rx_byte, byte_nxt;
    logic                 parity_err, perr_o_nxt;
    logic                 frame_err, ferr_o_nxt;
    logic                 brk, brk_nxt;
    logic                 half_end, bit_end;

    // The IDLE cycle that saw the falling edge counts as the first half-bit
    // cycle, so the start-bit check lands on edge 2+H after the pin went low.
    assign half_end = (clk_cnt == CNT_W'(H - 1));
    assign bit_end  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = clk_cnt;
        idx_nxt    = bit_idx;
        stop_nxt   = stop_idx;
        shift_nxt  = shift;
        perr_nxt   = perr;
        ferr_nxt   = ferr;
        zero_nxt   = zero_run;
        dv_nxt     = 1'b0;
        byte_nxt   = rx_byte;
        perr_o_nxt = parity_err;
        ferr_o_nxt = frame_err;
        brk_nxt    = brk;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (half_end) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                        stop_nxt  = 1'b0;
                        perr_nxt  = 1'b0;
                        ferr_nxt  = 1'b0;
                        zero_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    zero_nxt           = zero_run & ~rx_s;
                    if (bit_idx == IDX_W'(DATA_BITS - 1))
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    else
                        idx_nxt = bit_idx + IDX_W'(1);
                end else begin
                    cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    perr_nxt  = rx_s != parity_bit(MAX_DATA_BITS'(shift), PARITY_ODD != 0);
                    zero_nxt  = zero_run & ~rx_s;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nxt  = '0;
                    ferr_nxt = ferr | ~rx_s;
                    // Break only looks at the first stop bit.
                    if (!stop_idx) zero_nxt = zero_run & ~rx_s;
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        dv_nxt     = 1'b1;
                        byte_nxt   = shift_nxt;
                        perr_o_nxt = perr;
                        ferr_o_nxt = ferr_nxt;
                        brk_nxt    = zero_nxt;
                        state_nxt  = CLEANUP;
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end
            CLEANUP: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            zero_run   <= 1'b0;
            rx_dv      <= 1'b0;
            rx_byte    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            brk        <= 1'b0;
        end else begin
            state      <= state_nxt;
            clk_cnt    <= cnt_nxt;
            bit_idx    <= idx_nxt;
            stop_idx   <= stop_nxt;
            shift      <= shift_nxt;
            perr       <= perr_nxt;
            ferr       <= ferr_nxt;
            zero_run   <= zero_nxt;
            rx_dv      <= dv_nxt;
            rx_byte    <= byte_nxt;
            parity_err <= perr_o_nxt;
            frame_err  <= ferr_o_nxt;
            brk        <= brk_nxt;
        end
    end

    assign o_Rx_DV      = rx_dv;
    assign o_Rx_Byte    = rx_byte;
    assign o_Parity_Err = parity_err;
    assign o_Frame_Err  = frame_err;
    assign o_Break      = brk;
    assign o_Rx_Busy    = (state != IDLE);
    assign o_Rx_SM      = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four configurations driven by a frame table,
// directed corner sequences, and random frames against a bit-level model.
module tb_uart_rx_cfg;

    // Configurations: 0 = 8N1@434, 1 = 8E1@20, 2 = 7N2@434, 3 = 9O2@16
    localparam int A_CPB = 434, B_CPB = 20, C_CPB = 434, D_CPB = 16;

    int cpb_of   [4] = '{A_CPB, B_CPB, C_CPB, D_CPB};
    int nbits_of [4] = '{8, 8, 7, 9};
    int npar_of  [4] = '{0, 1, 0, 1};
    int odd_of   [4] = '{0, 0, 0, 1};
    int nstop_of [4] = '{1, 1, 2, 2};

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       rst_o = 1'b0;
    logic [3:0] rx = 4'hF;
    logic [3:0] dv, pe, fe, bk, busy;
    logic [7:0] byte_a, byte_b;
    logic [6:0] byte_c;
    logic [8:0] byte_d;
    logic [2:0] sm_a, sm_b, sm_c, sm_d;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(A_CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .i_Clock(clk), .i_Rst_n(rst_a), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Byte(byte_a),
        .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(bk[0]), .o_Rx_Busy(busy[0]), .o_Rx_SM(sm_a));
    uart_rx_cfg #(.CLKS_PER_BIT(B_CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .i_Clock(clk), .i_Rst_n(rst_o), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Byte(byte_b),
        .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(bk[1]), .o_Rx_Busy(busy[1]), .o_Rx_SM(sm_b));
    uart_rx_cfg #(.CLKS_PER_BIT(C_CPB), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
        .i_Clock(clk), .i_Rst_n(rst_o), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Byte(byte_c),
        .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(bk[2]), .o_Rx_Busy(busy[2]), .o_Rx_SM(sm_c));
    uart_rx_cfg #(.CLKS_PER_BIT(D_CPB), .DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_d (
        .i_Clock(clk), .i_Rst_n(rst_o), .i_Rx_Serial(rx[3]), .o_Rx_DV(dv[3]), .o_Rx_Byte(byte_d),
        .o_Parity_Err(pe[3]), .o_Frame_Err(fe[3]), .o_Break(bk[3]), .o_Rx_Busy(busy[3]), .o_Rx_SM(sm_d));

    typedef struct {
        int         c;
        logic [8:0] b;
        logic       pe, fe, bk;
    } dv_rec_t;

    dv_rec_t q0[$], q1[$], q2[$], q3[$];

    function automatic dv_rec_t mk(input int c, input logic [8:0] b, input logic p, input logic f, input logic k);
        dv_rec_t r;
        r.c = c; r.b = b; r.pe = p; r.fe = f; r.bk = k;
        return r;
    endfunction

    always @(negedge clk) begin
        if (dv[0]) q0.push_back(mk(cyc, 9'(byte_a), pe[0], fe[0], bk[0]));
        if (dv[1]) q1.push_back(mk(cyc, 9'(byte_b), pe[1], fe[1], bk[1]));
        if (dv[2]) q2.push_back(mk(cyc, 9'(byte_c), pe[2], fe[2], bk[2]));
        if (dv[3]) q3.push_back(mk(cyc, byte_d, pe[3], fe[3], bk[3]));
    end

    function automatic int qn(input int s);
        case (s)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [2:0] sm_of(input int s);
        case (s)
            0: return sm_a;
            1: return sm_b;
            2: return sm_c;
            default: return sm_d;
        endcase
    endfunction

    // {dv, byte, parity, frame, break, busy, sm}; all zero in reset
    function automatic logic [16:0] outs_of(input int s);
        logic [8:0] b;
        case (s)
            0: b = 9'(byte_a);
            1: b = 9'(byte_b);
            2: b = 9'(byte_c);
            default: b = byte_d;
        endcase
        return {dv[s], b, pe[s], fe[s], bk[s], busy[s], sm_of(s)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input int n);
        rx[s] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int s, input logic [8:0] d, input logic par,
                              input logic [1:0] stp, output int t0);
        t0 = cyc;
        drive(s, 1'b0, cpb_of[s]);
        for (int i = 0; i < nbits_of[s]; i++) drive(s, d[i], cpb_of[s]);
        if (npar_of[s] != 0) drive(s, par, cpb_of[s]);
        for (int i = 0; i < nstop_of[s]; i++) drive(s, stp[i], cpb_of[s]);
    endtask

    task automatic get_dv(input int s, output dv_rec_t r, output bit ok);
        ok = 1'b0;
        r = mk(0, 9'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64 && !ok; i++) begin
            if (qn(s) > 0) begin
                case (s)
                    0: r = q0.pop_front();
                    1: r = q1.pop_front();
                    2: r = q2.pop_front();
                    default: r = q3.pop_front();
                endcase
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL dv_timeout cfg %0d: no DV seen, expected one", s);
        end
    endtask

    typedef struct {
        int         s;
        logic [8:0] d;
        logic       par;
        logic [1:0] stp;
        logic [8:0] e_byte;
        logic       e_pe, e_fe, e_bk;
    } vec_t;

    vec_t vt [11];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        dv_rec_t r;
        bit      ok;
        int      t0, n0, lat;
        logic [8:0] d;
        logic       par, ep;
        logic [1:0] stp;

        vt[0]  = '{0, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{0, 9'h03F, 1'b0, 2'b10, 9'h03F, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1, 9'h0A3, 1'b1, 2'b11, 9'h0A3, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1, 9'h0A3, 1'b0, 2'b11, 9'h0A3, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1, 9'h000, 1'b0, 2'b10, 9'h000, 1'b0, 1'b1, 1'b1};
        vt[6]  = '{1, 9'h000, 1'b1, 2'b10, 9'h000, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{2, 9'h02A, 1'b0, 2'b11, 9'h02A, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{3, 9'h1FF, 1'b0, 2'b11, 9'h1FF, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{3, 9'h101, 1'b1, 2'b01, 9'h101, 1'b0, 1'b1, 1'b0};
        vt[10] = '{3, 9'h000, 1'b0, 2'b10, 9'h000, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) check($sformatf("reset_outs cfg%0d", s), 64'(outs_of(s)), 64'd0);
        rst_a = 1'b1;
        rst_o = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Frame table
        for (int i = 0; i < 11; i++) begin
            int s;
            s = vt[i].s;
            send_frame(s, vt[i].d, vt[i].par, vt[i].stp, t0);
            drive(s, 1'b1, 2 * cpb_of[s]);
            get_dv(s, r, ok);
            if (ok) begin
                lat = 3 + (cpb_of[s] - 1) / 2 + cpb_of[s] * (nbits_of[s] + npar_of[s] + nstop_of[s]);
                check($sformatf("vec%0d byte", i), 64'(r.b), 64'(vt[i].e_byte));
                check($sformatf("vec%0d parity_err", i), 64'(r.pe), 64'(vt[i].e_pe));
                check($sformatf("vec%0d frame_err", i), 64'(r.fe), 64'(vt[i].e_fe));
                check($sformatf("vec%0d break", i), 64'(r.bk), 64'(vt[i].e_bk));
                check($sformatf("vec%0d latency", i), 64'(r.c - t0), 64'(lat));
            end
            check($sformatf("vec%0d extra_dv", i), 64'(qn(s)), 64'd0);
            check($sformatf("vec%0d sm_idle", i), 64'(sm_of(s)), 64'd0);
        end

        // Start-bit glitch shorter than half a bit
        n0 = qn(0);
        drive(0, 1'b0, 100);
        check("glitch sm_start", 64'(sm_a), 64'd1);
        drive(0, 1'b1, 300);
        check("glitch sm_idle", 64'(sm_a), 64'd0);
        check("glitch busy", 64'(busy[0]), 64'd0);
        check("glitch no_dv", 64'(qn(0)), 64'(n0));

        // Asynchronous reset in the middle of a 0x55 frame
        drive(0, 1'b0, A_CPB);
        drive(0, 1'b1, A_CPB);
        drive(0, 1'b0, A_CPB);
        drive(0, 1'b1, A_CPB);
        drive(0, 1'b0, A_CPB);
        check("midreset sm_data", 64'(sm_a), 64'd2);
        rst_a = 1'b0;
        rx[0] = 1'b1;
        #1;
        check("midreset async_outs", 64'(outs_of(0)), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midreset held_outs", 64'(outs_of(0)), 64'd0);
        rst_a = 1'b1;
        drive(0, 1'b1, 2 * A_CPB);
        check("midreset no_dv", 64'(qn(0)), 64'd0);
        send_frame(0, 9'h03F, 1'b0, 2'b11, t0);
        drive(0, 1'b1, 2 * A_CPB);
        get_dv(0, r, ok);
        if (ok) begin
            check("midreset byte", 64'(r.b), 64'h3F);
            check("midreset flags", 64'({r.pe, r.fe, r.bk}), 64'd0);
        end
        check("midreset single_dv", 64'(qn(0)), 64'd0);

        // Line held low for 20 bit periods
        drive(0, 1'b0, 20 * A_CPB);
        check("break dv_count", 64'(qn(0)), 64'd1);
        get_dv(0, r, ok);
        if (ok) begin
            check("break byte", 64'(r.b), 64'd0);
            check("break flag", 64'(r.bk), 64'd1);
            check("break frame_err", 64'(r.fe), 64'd1);
            check("break parity_err", 64'(r.pe), 64'd0);
        end
        check("break sm_cleanup", 64'(sm_a), 64'd5);
        drive(0, 1'b1, 10);
        check("break sm_idle", 64'(sm_a), 64'd0);
        drive(0, 1'b1, 2 * A_CPB);
        check("break no_second_dv", 64'(qn(0)), 64'd0);

        // Random 9O2 frames, some back to back, with injected errors
        for (int i = 0; i < 40; i++) begin
            d = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 5) == 0) d = 9'd0;
            ep  = (^d) ^ 1'b1;
            par = ($urandom_range(0, 3) != 0) ? ep : ~ep;
            stp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            send_frame(3, d, par, stp, t0);
            drive(3, 1'b1, stp[1] ? $urandom_range(1, 2 * D_CPB) : D_CPB + $urandom_range(1, D_CPB));
            get_dv(3, r, ok);
            if (ok) begin
                check($sformatf("rand%0d byte", i), 64'(r.b), 64'(d));
                check($sformatf("rand%0d parity_err", i), 64'(r.pe), 64'(par != ep));
                check($sformatf("rand%0d frame_err", i), 64'(r.fe), 64'(!(stp[0] && stp[1])));
                check($sformatf("rand%0d break", i), 64'(r.bk), 64'(d == 9'd0 && !par && !stp[0]));
            end
        end
        drive(3, 1'b1, 2 * D_CPB);
        check("rand extra_dv", 64'(qn(3)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
